// File: rtl/dota_cal_seq.sv
// Sequencer for the inverter-based digital OTA comparator: SAR offset-trim
// calibration with shorted inputs, then majority-voted single-shot comparisons.
module dota_cal_seq #(
  parameter int TRIM_W     = 4,
  parameter int SETTLE_CYC = 4,
  parameter int NSAMP      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_start,
  input  logic              meas_req,
  input  logic              cmp_in,
  output logic              ota_en,
  output logic              cal_short,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              cal_done,
  output logic              cal_valid,
  output logic              meas_valid,
  output logic              meas_result
);

  localparam int CNT_MAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ONES_W  = $clog2(NSAMP + 1);
  localparam int IDX_W   = $clog2(TRIM_W);

  localparam logic [TRIM_W-1:0] TRIM_MID   = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_END = CNT_W'(NSAMP - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ONES_W-1:0] HALF       = ONES_W'(NSAMP / 2);
  localparam logic [IDX_W-1:0]  IDX_MSB    = IDX_W'(TRIM_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DECIDE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                mode_cal_q, mode_cal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic                meas_result_q, meas_result_d;
  logic                cal_valid_q, cal_valid_d;
  logic                sync1_q, sync2_q;
  logic                decision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_cal_q    <= 1'b0;
      cnt_q         <= '0;
      ones_q        <= '0;
      idx_q         <= '0;
      trim_q        <= TRIM_MID;
      meas_result_q <= 1'b0;
      cal_valid_q   <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_cal_q    <= mode_cal_d;
      cnt_q         <= cnt_d;
      ones_q        <= ones_d;
      idx_q         <= idx_d;
      trim_q        <= trim_d;
      meas_result_q <= meas_result_d;
      cal_valid_q   <= cal_valid_d;
      sync1_q       <= cmp_in;
      sync2_q       <= sync1_q;
    end
  end

  // The vote reads the registered ones count, so both modes pass through DECIDE.
  assign decision = (ones_q > HALF);

  always_comb begin
    state_d       = state_q;
    mode_cal_d    = mode_cal_q;
    cnt_d         = cnt_q;
    ones_d        = ones_q;
    idx_d         = idx_q;
    trim_d        = trim_q;
    meas_result_d = meas_result_q;
    cal_valid_d   = cal_valid_q;

    case (state_q)
      IDLE: begin
        if (cal_start) begin
          mode_cal_d = 1'b1;
          idx_d      = IDX_MSB;
          trim_d     = TRIM_MID;
          cnt_d      = '0;
          state_d    = SETTLE;
        end else if (meas_req) begin
          mode_cal_d = 1'b0;
          cnt_d      = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SAMPLE: begin
        ones_d = ones_q + ONES_W'(sync2_q);
        if (cnt_q == SAMPLE_END) begin
          cnt_d   = '0;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DECIDE: begin
        state_d = DONE;
        if (mode_cal_q) begin
          // A high comparator output means the trial code overshoots.
          if (decision) trim_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            trim_d[idx_q - IDX_ONE] = 1'b1;
            idx_d                   = idx_q - IDX_ONE;
            state_d                 = SETTLE;
          end else begin
            cal_valid_d = 1'b1;
          end
        end else begin
          meas_result_d = decision;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign ota_en      = busy;
  assign cal_short   = busy && mode_cal_q;
  assign cal_done    = (state_q == DONE) && mode_cal_q;
  assign meas_valid  = (state_q == DONE) && !mode_cal_q;
  assign cal_valid   = cal_valid_q;
  assign meas_result = meas_result_q;
  assign trim        = trim_q;

endmodule

// File: tb/tb_dota_cal_seq.sv
// Self-checking bench for dota_cal_seq: directed scenarios plus randomized
// thresholds and sample windows checked against a behavioural SAR/majority model.
module tb_dota_cal_seq;

  localparam int TRIM_W     = 4;
  localparam int SETTLE_CYC = 4;
  localparam int NSAMP      = 3;

  logic              clk;
  logic              rst_n;
  logic              cal_start;
  logic              meas_req;
  logic              cmp_in;
  logic              ota_en;
  logic              cal_short;
  logic [TRIM_W-1:0] trim;
  logic              busy;
  logic              cal_done;
  logic              cal_valid;
  logic              meas_valid;
  logic              meas_result;

  logic              use_thr;
  logic [4:0]        thr;
  logic              cmp_drv;
  logic [3:0]        model_trim;
  int                total;
  int                bad;

  dota_cal_seq #(
    .TRIM_W(TRIM_W),
    .SETTLE_CYC(SETTLE_CYC),
    .NSAMP(NSAMP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cal_start(cal_start),
    .meas_req(meas_req),
    .cmp_in(cmp_in),
    .ota_en(ota_en),
    .cal_short(cal_short),
    .trim(trim),
    .busy(busy),
    .cal_done(cal_done),
    .cal_valid(cal_valid),
    .meas_valid(meas_valid),
    .meas_result(meas_result)
  );

  // OTA model: either a trim threshold (comparator flips once trim >= thr) or a driven level.
  assign cmp_in = use_thr ? ({1'b0, trim} >= thr) : cmp_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic mr);
    cal_start = cs;
    meas_req  = mr;
    tick;
    cal_start = 1'b0;
    meas_req  = 1'b0;
  endtask

  // Full calibration against threshold t; expected trials come from a plain binary search.
  task automatic runCal(input logic [4:0] t, input logic with_meas, input string tag);
    logic [3:0] trials [4];
    logic [3:0] code;
    logic [3:0] trial;
    int         seen;
    code = 4'd0;
    for (int b = 3; b >= 0; b--) begin
      trial         = code | (4'd1 << b);
      trials[3 - b] = trial;
      if ({1'b0, trial} < t) code = trial;
    end
    thr     = t;
    use_thr = 1'b1;
    seen    = 0;
    applyStimulus(1'b1, with_meas);
    for (int e = 1; e <= 36; e++) begin
      meas_req = with_meas && (e == 4);
      tick;
      if (meas_valid) seen++;
      if ((e % 8 == 1) && (e < 32)) checkOutput({tag, "_trial"}, 8'(trim), 8'(trials[e / 8]));
      if (e == 16) checkOutput({tag, "_short_mid"}, 8'(cal_short), 8'd1);
      if (e == 31) checkOutput({tag, "_done_early"}, 8'(cal_done), 8'd0);
      if (e == 32) begin
        checkOutput({tag, "_done_pulse"}, 8'(cal_done), 8'd1);
        checkOutput({tag, "_busy_done"}, 8'(busy), 8'd1);
      end
      if (e == 33) begin
        checkOutput({tag, "_done_end"}, 8'(cal_done), 8'd0);
        checkOutput({tag, "_valid"}, 8'(cal_valid), 8'd1);
        checkOutput({tag, "_final"}, 8'(trim), 8'(code));
        checkOutput({tag, "_short_end"}, 8'(cal_short), 8'd0);
        checkOutput({tag, "_busy_end"}, 8'(busy), 8'd0);
      end
    end
    meas_req = 1'b0;
    checkOutput({tag, "_no_meas_valid"}, 8'(seen), 8'd0);
    model_trim = code;
  endtask

  // One measurement; win holds the three synchronized samples in order, surrounded by the opposite value.
  task automatic runMeas(input logic [2:0] win, input string tag);
    logic       exp_res;
    logic [9:0] p;
    exp_res = ($countones(win) > 1);
    p       = {10{~exp_res}};
    p[3]    = win[2];
    p[4]    = win[1];
    p[5]    = win[0];
    use_thr = 1'b0;
    cmp_drv = p[0];
    applyStimulus(1'b0, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      cmp_drv = p[e];
      tick;
      if (e == 5) checkOutput({tag, "_short"}, 8'(cal_short), 8'd0);
      if (e == 7) checkOutput({tag, "_valid_early"}, 8'(meas_valid), 8'd0);
      if (e == 8) begin
        checkOutput({tag, "_valid"}, 8'(meas_valid), 8'd1);
        checkOutput({tag, "_result"}, 8'(meas_result), 8'(exp_res));
        checkOutput({tag, "_busy_done"}, 8'(busy), 8'd1);
        checkOutput({tag, "_cal_done"}, 8'(cal_done), 8'd0);
        checkOutput({tag, "_trim"}, 8'(trim), 8'(model_trim));
      end
      if (e == 9) begin
        checkOutput({tag, "_valid_end"}, 8'(meas_valid), 8'd0);
        checkOutput({tag, "_held"}, 8'(meas_result), 8'(exp_res));
        checkOutput({tag, "_busy_end"}, 8'(busy), 8'd0);
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    cal_start  = 1'b0;
    meas_req   = 1'b0;
    use_thr    = 1'b0;
    cmp_drv    = 1'b1;
    thr        = 5'd11;
    model_trim = 4'b1000;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_trim", 8'(trim), 8'h08);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_ota_en", 8'(ota_en), 8'd0);
    checkOutput("rst_short", 8'(cal_short), 8'd0);
    checkOutput("rst_cal_valid", 8'(cal_valid), 8'd0);
    checkOutput("rst_meas_valid", 8'(meas_valid), 8'd0);
    rst_n = 1'b1;
    repeat (4) tick;
    checkOutput("idle_trim", 8'(trim), 8'h08);
    checkOutput("idle_busy", 8'(busy), 8'd0);
    checkOutput("idle_done", 8'(cal_done), 8'd0);
    checkOutput("idle_meas_valid", 8'(meas_valid), 8'd0);

    $display("[TB] directed calibration, threshold 11");
    runCal(5'd11, 1'b0, "cal11");

    $display("[TB] majority measurements");
    runMeas(3'b101, "meas101");
    runMeas(3'b010, "meas010");

    $display("[TB] simultaneous request and mid-calibration meas_req");
    runCal(5'd11, 1'b1, "calsim");

    $display("[TB] reset mid-calibration");
    thr     = 5'd11;
    use_thr = 1'b1;
    applyStimulus(1'b1, 1'b0);
    repeat (12) tick;
    checkOutput("midrst_valid_before", 8'(cal_valid), 8'd1);
    checkOutput("midrst_trim_before", 8'(trim), 8'h0c);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_trim", 8'(trim), 8'h08);
    checkOutput("midrst_valid", 8'(cal_valid), 8'd0);
    checkOutput("midrst_busy", 8'(busy), 8'd0);
    checkOutput("midrst_short", 8'(cal_short), 8'd0);
    tick;
    tick;
    rst_n      = 1'b1;
    model_trim = 4'b1000;
    tick;
    runMeas(3'b110, "meas_after_rst");

    $display("[TB] back-to-back requests");
    use_thr = 1'b0;
    cmp_drv = 1'b1;
    applyStimulus(1'b0, 1'b1);
    repeat (8) tick;
    checkOutput("b2b_first_valid", 8'(meas_valid), 8'd1);
    checkOutput("b2b_first_result", 8'(meas_result), 8'd1);
    meas_req = 1'b1;
    cmp_drv  = 1'b0;
    tick;
    tick;
    meas_req = 1'b0;
    for (int e = 11; e <= 19; e++) begin
      tick;
      if (e == 17) checkOutput("b2b_done_req_ignored", 8'(meas_valid), 8'd0);
      if (e == 18) begin
        checkOutput("b2b_second_valid", 8'(meas_valid), 8'd1);
        checkOutput("b2b_second_result", 8'(meas_result), 8'd0);
      end
      if (e == 19) checkOutput("b2b_second_end", 8'(meas_valid), 8'd0);
    end

    $display("[TB] randomized calibrations and measurements");
    for (int r = 0; r < 4; r++) begin
      runCal(5'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), $sformatf("rcal%0d", r));
      for (int m = 0; m < 2; m++) begin
        runMeas(3'($urandom_range(0, 7)), $sformatf("rmeas%0d_%0d", r, m));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
